// File: rtl/stmach_lap_v.sv
// Stopwatch control FSM with a prescaled elapsed counter and a small lap FIFO.
// Lap FIFO is show-ahead: lap_data presents the oldest entry, or 0 when empty.
module stmach_lap_v #(
  parameter int unsigned CNT_W    = 24,
  parameter int unsigned PRESCALE = 10,
  parameter int unsigned LAPS     = 4
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             DCM_lock,
  input  logic             strtstop,
  input  logic             lap,
  input  logic             lap_rd,
  output logic             clken,
  output logic             rst,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] lap_data,
  output logic             lap_valid,
  output logic             lap_full,
  output logic             lap_ovf,
  output logic             cnt_ovf
);

  localparam int unsigned PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned AW    = $clog2(LAPS);
  localparam int unsigned PTR_W = AW + 1;

  localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(PRESCALE - 1);

  localparam logic [1:0] CLEAR  = 2'd0;
  localparam logic [1:0] ZERO   = 2'd1;
  localparam logic [1:0] RUN    = 2'd2;
  localparam logic [1:0] PAUSED = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             strt_q, lap_q;
  logic             strt_ev, lap_ev;
  logic [PSC_W-1:0] psc_q, psc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             cnt_ovf_q, cnt_ovf_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             lap_ovf_q, lap_ovf_d;
  logic [CNT_W-1:0] mem [LAPS];

  logic clr, in_run, tick;
  logic push_req, push_ok, pop, fifo_empty, fifo_full;

  // Edge detectors are not cleared by CLEAR so a held button cannot re-fire.
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      strt_q <= 1'b0;
      lap_q  <= 1'b0;
    end else begin
      strt_q <= strtstop;
      lap_q  <= lap;
    end
  end

  assign strt_ev = strtstop & ~strt_q;
  assign lap_ev  = lap & ~lap_q;

  always_comb begin
    state_d = state_q;
    if (!DCM_lock) begin
      state_d = CLEAR;
    end else begin
      case (state_q)
        CLEAR:  state_d = ZERO;
        ZERO:   if (strt_ev) state_d = RUN;
        RUN:    if (strt_ev) state_d = PAUSED;
        PAUSED: begin
          if (strt_ev)     state_d = RUN;
          else if (lap_ev) state_d = CLEAR;
        end
        default: state_d = CLEAR;
      endcase
    end
  end

  // Datapath is zeroed on the edge that enters CLEAR, so it reads 0 throughout CLEAR.
  assign clr    = (state_d == CLEAR);
  assign in_run = (state_q == RUN);
  assign tick   = in_run && (psc_q == PSC_MAX);

  always_comb begin
    psc_d = psc_q;
    if (clr) begin
      psc_d = '0;
    end else if (in_run) begin
      psc_d = tick ? '0 : psc_q + PSC_W'(1);
    end
  end

  always_comb begin
    count_d   = count_q;
    cnt_ovf_d = cnt_ovf_q;
    if (clr) begin
      count_d   = '0;
      cnt_ovf_d = 1'b0;
    end else if (tick) begin
      count_d = count_q + CNT_W'(1);
      if (&count_q) cnt_ovf_d = 1'b1;
    end
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // strtstop wins over a coincident lap event, so no push on that cycle.
  assign push_req = in_run && DCM_lock && lap_ev && !strt_ev;
  assign pop      = lap_rd && !fifo_empty && (state_q != CLEAR) && !clr;
  assign push_ok  = push_req && (!fifo_full || pop);

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    lap_ovf_d = lap_ovf_q;
    if (clr) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      lap_ovf_d = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_req && fifo_full && !pop) lap_ovf_d = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q   <= CLEAR;
      psc_q     <= '0;
      count_q   <= '0;
      cnt_ovf_q <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      lap_ovf_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      psc_q     <= psc_d;
      count_q   <= count_d;
      cnt_ovf_q <= cnt_ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      lap_ovf_q <= lap_ovf_d;
    end
  end

  // Storage needs no reset: entries are only visible through a valid read pointer.
  always_ff @(posedge CLK) begin
    if (push_ok) begin
      mem[wr_ptr_q[AW-1:0]] <= count_q;
    end
  end

  assign clken     = (state_q == RUN);
  assign rst       = (state_q == CLEAR);
  assign count     = count_q;
  assign lap_valid = !fifo_empty;
  assign lap_full  = fifo_full;
  assign lap_data  = fifo_empty ? '0 : mem[rd_ptr_q[AW-1:0]];
  assign lap_ovf   = lap_ovf_q;
  assign cnt_ovf   = cnt_ovf_q;

endmodule

// File: tb/tb_stmach_lap_v.sv
// Directed bench for stmach_lap_v: a default-parameter instance (a_*) and a fast
// 8-bit, PRESCALE=1 instance (b_*) share the same stimulus.
module tb_stmach_lap_v;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic reset, DCM_lock, strtstop, lap, lap_rd;

  logic        a_clken, a_rst, a_lap_valid, a_lap_full, a_lap_ovf, a_cnt_ovf;
  logic [23:0] a_count, a_lap_data;
  logic        b_clken, b_rst, b_lap_valid, b_lap_full, b_lap_ovf, b_cnt_ovf;
  logic [7:0]  b_count, b_lap_data;

  int checks = 0;
  int errors = 0;

  stmach_lap_v #(.CNT_W(24), .PRESCALE(10), .LAPS(4)) dut_a (
    .CLK(CLK), .reset(reset), .DCM_lock(DCM_lock), .strtstop(strtstop), .lap(lap),
    .lap_rd(lap_rd), .clken(a_clken), .rst(a_rst), .count(a_count), .lap_data(a_lap_data),
    .lap_valid(a_lap_valid), .lap_full(a_lap_full), .lap_ovf(a_lap_ovf), .cnt_ovf(a_cnt_ovf)
  );

  stmach_lap_v #(.CNT_W(8), .PRESCALE(1), .LAPS(4)) dut_b (
    .CLK(CLK), .reset(reset), .DCM_lock(DCM_lock), .strtstop(strtstop), .lap(lap),
    .lap_rd(lap_rd), .clken(b_clken), .rst(b_rst), .count(b_count), .lap_data(b_lap_data),
    .lap_valid(b_lap_valid), .lap_full(b_lap_full), .lap_ovf(b_lap_ovf), .cnt_ovf(b_cnt_ovf)
  );

  // All tasks start and end at a falling edge.
  task automatic step(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic pulse_strt();
    strtstop = 1'b1;
    @(negedge CLK);
    strtstop = 1'b0;
  endtask

  task automatic pulse_lap();
    lap = 1'b1;
    @(negedge CLK);
    lap = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0; strtstop = 1'b0; lap = 1'b0; lap_rd = 1'b0; DCM_lock = 1'b1;
    step(2);
    reset = 1'b1;
    step(1);
  endtask

  task automatic test_reset();
    #2;
    checks++; if (a_rst !== 1'b1) begin errors++; $display("FAIL reset_rst: got %b want 1", a_rst); end
    checks++; if (a_clken !== 1'b0) begin errors++; $display("FAIL reset_clken: got %b want 0", a_clken); end
    checks++; if (a_count !== 24'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", a_count); end
    checks++; if ({a_lap_valid, a_lap_full, a_lap_ovf, a_cnt_ovf} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags: got %b want 0000",
                         {a_lap_valid, a_lap_full, a_lap_ovf, a_cnt_ovf});
    end
    checks++; if (a_lap_data !== 24'd0) begin errors++; $display("FAIL reset_lap_data: got %0d want 0", a_lap_data); end
    @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    checks++; if (a_rst !== 1'b0 || a_clken !== 1'b0) begin
      errors++; $display("FAIL reset_to_zero: got rst=%b clken=%b want 0 0", a_rst, a_clken);
    end
  endtask

  task automatic test_run_pause();
    do_reset();
    pulse_strt();
    checks++; if (a_clken !== 1'b1) begin errors++; $display("FAIL run_clken: got %b want 1", a_clken); end
    step(99);
    pulse_strt();
    checks++; if (a_count !== 24'd10) begin errors++; $display("FAIL pause_count: got %0d want 10", a_count); end
    checks++; if (a_clken !== 1'b0 || a_rst !== 1'b0) begin
      errors++; $display("FAIL pause_state: got clken=%b rst=%b want 0 0", a_clken, a_rst);
    end
    step(20);
    checks++; if (a_count !== 24'd10) begin errors++; $display("FAIL pause_hold: got %0d want 10", a_count); end
  endtask

  task automatic test_hold_level();
    do_reset();
    strtstop = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      checks++; if (a_clken !== 1'b1) begin errors++; $display("FAIL hold_run[%0d]: got %b want 1", i, a_clken); end
    end
    strtstop = 1'b0;
    step(3);
    checks++; if (a_clken !== 1'b1) begin errors++; $display("FAIL hold_release: got %b want 1", a_clken); end
  endtask

  task automatic test_lap_fifo();
    int exp_v[4] = '{3, 5, 7, 9};
    do_reset();
    pulse_strt();
    step(3);
    for (int i = 0; i < 5; i++) begin
      pulse_lap();
      if (i < 4) step(1);
    end
    pulse_strt();
    checks++; if (b_count !== 8'd13) begin errors++; $display("FAIL fifo_count: got %0d want 13", b_count); end
    checks++; if ({b_lap_valid, b_lap_full, b_lap_ovf} !== 3'b111) begin
      errors++; $display("FAIL fifo_full_ovf: got %b want 111", {b_lap_valid, b_lap_full, b_lap_ovf});
    end
    lap_rd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (b_lap_data !== 8'(exp_v[i])) begin
        errors++; $display("FAIL fifo_pop[%0d]: got %0d want %0d", i, b_lap_data, exp_v[i]);
      end
      @(negedge CLK);
    end
    lap_rd = 1'b0;
    checks++; if ({b_lap_valid, b_lap_full, b_lap_ovf} !== 3'b001) begin
      errors++; $display("FAIL fifo_empty: got %b want 001", {b_lap_valid, b_lap_full, b_lap_ovf});
    end
    checks++; if (b_lap_data !== 8'd0) begin errors++; $display("FAIL fifo_empty_data: got %0d want 0", b_lap_data); end
  endtask

  task automatic test_full_push_pop();
    int exp_v[4] = '{5, 7, 9, 11};
    do_reset();
    pulse_strt();
    step(3);
    for (int i = 0; i < 4; i++) begin
      pulse_lap();
      step(1);
    end
    checks++; if (b_lap_full !== 1'b1) begin errors++; $display("FAIL pp_full_before: got %b want 1", b_lap_full); end
    lap = 1'b1; lap_rd = 1'b1;
    @(negedge CLK);
    lap = 1'b0; lap_rd = 1'b0;
    checks++; if ({b_lap_valid, b_lap_full, b_lap_ovf} !== 3'b110) begin
      errors++; $display("FAIL pp_flags: got %b want 110", {b_lap_valid, b_lap_full, b_lap_ovf});
    end
    pulse_strt();
    lap_rd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (b_lap_data !== 8'(exp_v[i])) begin
        errors++; $display("FAIL pp_pop[%0d]: got %0d want %0d", i, b_lap_data, exp_v[i]);
      end
      @(negedge CLK);
    end
    lap_rd = 1'b0;
    checks++; if (b_lap_valid !== 1'b0) begin errors++; $display("FAIL pp_empty: got %b want 0", b_lap_valid); end
  endtask

  task automatic test_priority();
    do_reset();
    pulse_strt();
    step(4);
    strtstop = 1'b1; lap = 1'b1;
    @(negedge CLK);
    strtstop = 1'b0; lap = 1'b0;
    checks++; if ({b_clken, b_rst, b_lap_valid} !== 3'b000) begin
      errors++; $display("FAIL prio_run: got clken,rst,valid=%b want 000", {b_clken, b_rst, b_lap_valid});
    end
    step(1);
    strtstop = 1'b1; lap = 1'b1;
    @(negedge CLK);
    strtstop = 1'b0; lap = 1'b0;
    checks++; if (b_clken !== 1'b1 || b_rst !== 1'b0) begin
      errors++; $display("FAIL prio_paused: got clken=%b rst=%b want 1 0", b_clken, b_rst);
    end
    checks++; if (b_count !== 8'd5) begin errors++; $display("FAIL prio_count: got %0d want 5", b_count); end
  endtask

  task automatic test_wrap_clear();
    do_reset();
    pulse_strt();
    step(5);
    pulse_lap();
    step(249);
    pulse_strt();
    checks++; if (b_count !== 8'd0 || b_cnt_ovf !== 1'b1) begin
      errors++; $display("FAIL wrap: got count=%0d cnt_ovf=%b want 0 1", b_count, b_cnt_ovf);
    end
    checks++; if (b_lap_valid !== 1'b1 || b_lap_data !== 8'd5) begin
      errors++; $display("FAIL wrap_lap: got valid=%b data=%0d want 1 5", b_lap_valid, b_lap_data);
    end
    pulse_lap();
    checks++; if (b_rst !== 1'b1) begin errors++; $display("FAIL clear_rst: got %b want 1", b_rst); end
    checks++; if ({b_lap_valid, b_lap_full, b_lap_ovf, b_cnt_ovf} !== 4'b0000 || b_count !== 8'd0) begin
      errors++; $display("FAIL clear_flags: got flags=%b count=%0d want 0000 0",
                         {b_lap_valid, b_lap_full, b_lap_ovf, b_cnt_ovf}, b_count);
    end
    @(negedge CLK);
    checks++; if (b_rst !== 1'b0 || b_clken !== 1'b0) begin
      errors++; $display("FAIL clear_pulse_len: got rst=%b clken=%b want 0 0", b_rst, b_clken);
    end
  endtask

  task automatic test_dcm_lock();
    do_reset();
    pulse_strt();
    step(14);
    pulse_lap();
    step(10);
    checks++; if (a_count !== 24'd2 || a_lap_data !== 24'd1) begin
      errors++; $display("FAIL dcm_pre: got count=%0d lap_data=%0d want 2 1", a_count, a_lap_data);
    end
    DCM_lock = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      checks++; if (a_rst !== 1'b1 || a_clken !== 1'b0 || a_count !== 24'd0 || a_lap_valid !== 1'b0) begin
        errors++; $display("FAIL dcm_low[%0d]: got rst=%b clken=%b count=%0d valid=%b want 1 0 0 0",
                           i, a_rst, a_clken, a_count, a_lap_valid);
      end
    end
    DCM_lock = 1'b1;
    @(negedge CLK);
    checks++; if (a_rst !== 1'b0 || a_clken !== 1'b0) begin
      errors++; $display("FAIL dcm_zero: got rst=%b clken=%b want 0 0", a_rst, a_clken);
    end
    pulse_strt();
    checks++; if (a_clken !== 1'b1) begin errors++; $display("FAIL dcm_restart: got %b want 1", a_clken); end
  endtask

  task automatic test_async_reset();
    do_reset();
    pulse_strt();
    step(5);
    #2 reset = 1'b0;
    #1;
    checks++; if (a_rst !== 1'b1 || a_clken !== 1'b0 || b_count !== 8'd0) begin
      errors++; $display("FAIL async_reset: got rst=%b clken=%b count=%0d want 1 0 0",
                         a_rst, a_clken, b_count);
    end
    @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    checks++; if (a_rst !== 1'b0 || a_clken !== 1'b0) begin
      errors++; $display("FAIL async_release: got rst=%b clken=%b want 0 0", a_rst, a_clken);
    end
  endtask

  initial begin
    reset = 1'b0; DCM_lock = 1'b1; strtstop = 1'b0; lap = 1'b0; lap_rd = 1'b0;
    test_reset();
    test_run_pause();
    test_hold_level();
    test_lap_fifo();
    test_full_push_pop();
    test_priority();
    test_wrap_clear();
    test_dcm_lock();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
